// File: rtl/jt89_pkg.sv
// rtl/jt89_pkg.sv - shared constants and helpers for the jt89 stereo PSG
// Amplitude ROM, register indices and the noise-LFSR reset value.
package jt89_pkg;

  localparam logic [2:0] TONE0 = 3'd0;
  localparam logic [2:0] VOL0  = 3'd1;
  localparam logic [2:0] TONE1 = 3'd2;
  localparam logic [2:0] VOL1  = 3'd3;
  localparam logic [2:0] TONE2 = 3'd4;
  localparam logic [2:0] VOL2  = 3'd5;
  localparam logic [2:0] CTRL3 = 3'd6;
  localparam logic [2:0] VOL3  = 3'd7;

  // Index 0 is loudest; volume 15 is silence.
  localparam logic [15:0][7:0] AMP_ROM = {
    8'd0,   8'd10,  8'd13,  8'd16,  8'd20,  8'd26,  8'd32,  8'd40,
    8'd51,  8'd64,  8'd81,  8'd102, 8'd128, 8'd161, 8'd203, 8'd255
  };

  typedef enum logic [1:0] {
    NR_16    = 2'b00,
    NR_32    = 2'b01,
    NR_64    = 2'b10,
    NR_TONE2 = 2'b11
  } noise_rate_e;

  function automatic logic [31:0] lfsr_rst(input int width);
    lfsr_rst = 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/jt89_stereo_if.sv
// rtl/jt89_stereo_if.sv - CPU write bus and audio output bundle of the jt89 stereo PSG
interface jt89_stereo_if;
  logic        cs_n;
  logic        wr_n;
  logic        pan_we;
  logic [7:0]  din;
  logic        ready;
  logic        ovf;
  logic        sample;
  logic [10:0] snd_l;
  logic [10:0] snd_r;

  modport master (
    output cs_n, wr_n, pan_we, din,
    input  ready, ovf, sample, snd_l, snd_r
  );

  modport slave (
    input  cs_n, wr_n, pan_we, din,
    output ready, ovf, sample, snd_l, snd_r
  );
endinterface

// File: rtl/jt89_wfifo.sv
// rtl/jt89_wfifo.sv - byte-wide synchronous write FIFO with overflow pulse
// A pop on a full FIFO frees the slot so a same-cycle push is still accepted.
module jt89_wfifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       ovf_o
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];
  assign ovf_o   = ovf_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      ovf_q <= push_i & ~do_push;
    end
  end
endmodule

// File: rtl/jt89_stereo.sv
// rtl/jt89_stereo.sv - SN76489-family PSG: 3 tone + noise, GG stereo pan, buffered CPU writes
// All channel state advances on cen16, the registered 1/16 of clk_en.
module jt89_stereo
  import jt89_pkg::*;
#(
  parameter int              LFSRW   = 16,
  parameter logic [LFSRW-1:0] TAPS   = LFSRW'(16'h0009),
  parameter int              FIFO_AW = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          clk_en,
  jt89_stereo_if.slave bus
);
  localparam logic [LFSRW-1:0] LFSR_RST = LFSRW'(lfsr_rst(LFSRW));

  logic [3:0]       div16_q;
  logic             cen16_q, wr_act_q;
  logic             push, pop, fifo_full, fifo_empty, fifo_ovf;
  logic [7:0]       fifo_dout;
  logic [2:0]       reg_q, reg_d, ctrl3_q, ctrl3_d, sel;
  logic [9:0]       tone_q [3], tone_d [3], tcnt_q [3], tcnt_d [3];
  logic [3:0]       vol_q [4], vol_d [4];
  logic [2:0]       tout_q, tout_d;
  logic [7:0]       pan_q;
  logic             noise_clr, nclk_q, nclk_d, nsrc, nsrc_q, shift, fb;
  logic [5:0]       ncnt_q, ncnt_d, nreload;
  logic [LFSRW-1:0] lfsr_q, lfsr_d;
  logic [3:0]       ch_out;
  logic [3:0][8:0]  chan_v;
  logic [10:0]      mix_l, mix_r, snd_l_q, snd_r_q;
  logic             sample_q;

  assign push = ~bus.cs_n & ~bus.wr_n & ~wr_act_q;
  assign pop  = cen16_q & ~fifo_empty;

  jt89_wfifo #(.AW(FIFO_AW)) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (bus.din),
    .pop_i   (cen16_q),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .ovf_o   (fifo_ovf)
  );

  // Latched bytes select a register; data bytes reuse the last latched one.
  always_comb begin
    reg_d     = reg_q;
    ctrl3_d   = ctrl3_q;
    tone_d    = tone_q;
    vol_d     = vol_q;
    noise_clr = 1'b0;
    sel       = fifo_dout[7] ? fifo_dout[6:4] : reg_q;
    if (pop) begin
      if (fifo_dout[7]) reg_d = sel;
      if (sel == CTRL3) begin
        ctrl3_d   = fifo_dout[2:0];
        noise_clr = fifo_dout[7];
      end else if (sel[0]) begin
        vol_d[sel[2:1]] = fifo_dout[3:0];
      end else if (fifo_dout[7]) begin
        tone_d[sel[2:1]][3:0] = fifo_dout[3:0];
      end else begin
        tone_d[sel[2:1]][9:4] = fifo_dout[5:0];
      end
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    tout_d = tout_q;
    for (int i = 0; i < 3; i++) begin
      if (cen16_q) begin
        if (tone_q[i] <= 10'd1) begin
          tcnt_d[i] = tone_q[i];
          tout_d[i] = 1'b1;
        end else if (tcnt_q[i] == '0) begin
          tcnt_d[i] = tone_q[i];
          tout_d[i] = ~tout_q[i];
        end else begin
          tcnt_d[i] = tcnt_q[i] - 10'd1;
        end
      end
    end
  end

  always_comb begin
    unique case (noise_rate_e'(ctrl3_q[1:0]))
      NR_32:   nreload = 6'd31;
      NR_64:   nreload = 6'd63;
      default: nreload = 6'd15;
    endcase
    ncnt_d = ncnt_q;
    nclk_d = nclk_q;
    if (cen16_q) begin
      if (ncnt_q == '0) begin
        ncnt_d = nreload;
        nclk_d = ~nclk_q;
      end else begin
        ncnt_d = ncnt_q - 6'd1;
      end
    end
    nsrc  = (noise_rate_e'(ctrl3_q[1:0]) == NR_TONE2) ? tout_q[2] : nclk_q;
    shift = nsrc & ~nsrc_q;
    fb    = ctrl3_q[2] ? ^(lfsr_q & TAPS) : lfsr_q[0];
    if (noise_clr || lfsr_q == '0) lfsr_d = LFSR_RST;
    else if (shift)                lfsr_d = {fb, lfsr_q[LFSRW-1:1]};
    else                           lfsr_d = lfsr_q;
  end

  assign ch_out = {lfsr_q[0], tout_q};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    logic [8:0] amp9;
    assign amp9      = {1'b0, AMP_ROM[vol_q[i]]};
    assign chan_v[i] = ch_out[i] ? amp9 : 9'd0 - amp9;
  end

  always_comb begin
    mix_l = '0;
    mix_r = '0;
    for (int i = 0; i < 4; i++) begin
      if (pan_q[4+i]) mix_l = mix_l + {{2{chan_v[i][8]}}, chan_v[i]};
      if (pan_q[i])   mix_r = mix_r + {{2{chan_v[i][8]}}, chan_v[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div16_q  <= '0;
      cen16_q  <= 1'b0;
      wr_act_q <= 1'b0;
      reg_q    <= '0;
      ctrl3_q  <= 3'b100;
      pan_q    <= 8'hFF;
      for (int i = 0; i < 3; i++) begin
        tone_q[i] <= '0;
        tcnt_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) vol_q[i] <= 4'hF;
      tout_q   <= 3'b111;
      ncnt_q   <= '0;
      nclk_q   <= 1'b0;
      nsrc_q   <= 1'b0;
      lfsr_q   <= LFSR_RST;
      snd_l_q  <= '0;
      snd_r_q  <= '0;
      sample_q <= 1'b0;
    end else begin
      if (clk_en) div16_q <= div16_q + 4'd1;
      cen16_q  <= clk_en & (div16_q == 4'hF);
      wr_act_q <= ~bus.cs_n & ~bus.wr_n;
      reg_q    <= reg_d;
      ctrl3_q  <= ctrl3_d;
      if (bus.pan_we) pan_q <= bus.din;
      tone_q   <= tone_d;
      vol_q    <= vol_d;
      tcnt_q   <= tcnt_d;
      tout_q   <= tout_d;
      ncnt_q   <= ncnt_d;
      nclk_q   <= nclk_d;
      nsrc_q   <= nsrc;
      lfsr_q   <= lfsr_d;
      sample_q <= cen16_q;
      if (cen16_q) begin
        snd_l_q <= mix_l;
        snd_r_q <= mix_r;
      end
    end
  end

  assign bus.ready  = ~fifo_full;
  assign bus.ovf    = fifo_ovf;
  assign bus.sample = sample_q;
  assign bus.snd_l  = snd_l_q;
  assign bus.snd_r  = snd_r_q;
endmodule

// File: tb/tb_jt89_stereo.sv
// tb/tb_jt89_stereo.sv - directed self-checking bench for jt89_stereo
module tb_jt89_stereo;
  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  int   n_pass;
  int   n_total;
  logic d_ovf, d_rdy;

  jt89_stereo_if bus ();

  jt89_stereo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded 90000 cycles");
    $fatal(1);
  end

  task automatic wr_byte(input logic [7:0] b, output logic ovf_seen, output logic rdy_after);
    @(negedge clk);
    bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.din = b;
    @(posedge clk);
    #1;
    ovf_seen  = bus.ovf;
    rdy_after = bus.ready;
    @(negedge clk);
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  task automatic pan_write(input logic [7:0] b);
    @(negedge clk);
    bus.pan_we = 1'b1; bus.din = b;
    @(negedge clk);
    bus.pan_we = 1'b0;
  endtask

  task automatic get_sample(output int l, output int r);
    l = 0; r = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.sample === 1'b1) begin
        l = $signed(bus.snd_l);
        r = $signed(bus.snd_r);
        return;
      end
    end
    n_total++;
    $display("FAIL sample_timeout: no sample pulse within 64 clk");
  endtask

  task automatic test_reset();
    int l, r, bad;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else n_pass++;
    n_total++; if (bus.sample !== 1'b0) $display("FAIL reset_sample: got %b want 0", bus.sample); else n_pass++;
    n_total++; if (bus.snd_l !== 11'd0 || bus.snd_r !== 11'd0)
      $display("FAIL reset_snd: got l=%0d r=%0d want 0/0", bus.snd_l, bus.snd_r); else n_pass++;
    bad = 0;
    repeat (100) begin
      get_sample(l, r);
      if (l != 0 || r != 0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL reset_silence: %0d nonzero samples, want 0", bad); else n_pass++;
  endtask

  task automatic test_tone();
    int s[$];
    int l, r, k, last, ntr, gap_bad, amp_bad, lr_bad;
    wr_byte(8'h85, d_ovf, d_rdy);
    wr_byte(8'h00, d_ovf, d_rdy);
    wr_byte(8'h90, d_ovf, d_rdy);
    pan_write(8'hFF);
    k = 0; l = 0;
    do begin get_sample(l, r); k++; end while (l == 0 && k < 20);
    n_total++; if (l == 0) $display("FAIL tone_start: got snd_l=0 after %0d samples want +-255", k); else n_pass++;
    repeat (3) get_sample(l, r);
    amp_bad = 0; lr_bad = 0;
    repeat (42) begin
      get_sample(l, r);
      s.push_back(l);
      if ((l < 0 ? -l : l) != 255) amp_bad++;
      if (r != l) lr_bad++;
    end
    last = -1; ntr = 0; gap_bad = 0;
    for (int i = 1; i < s.size(); i++) begin
      if (s[i] != s[i-1]) begin
        if (last >= 0 && i - last != 6) gap_bad++;
        last = i;
        ntr++;
      end
    end
    n_total++; if (amp_bad != 0) $display("FAIL tone_amp: %0d samples not +-255", amp_bad); else n_pass++;
    n_total++; if (lr_bad != 0) $display("FAIL tone_lr: %0d samples with snd_r != snd_l", lr_bad); else n_pass++;
    n_total++; if (ntr < 6 || gap_bad != 0)
      $display("FAIL tone_period: transitions=%0d bad_gaps=%0d want >=6 transitions every 6 ticks", ntr, gap_bad);
    else n_pass++;
  endtask

  task automatic test_pan();
    logic [7:0] pv [3] = '{8'h0F, 8'hE0, 8'h10};
    int         el [3] = '{0, 0, 255};
    int         er [3] = '{255, 0, 0};
    int l, r, bad_l, bad_r;
    for (int t = 0; t < 3; t++) begin
      pan_write(pv[t]);
      repeat (2) get_sample(l, r);
      bad_l = 0; bad_r = 0;
      repeat (12) begin
        get_sample(l, r);
        if ((l < 0 ? -l : l) != el[t]) bad_l++;
        if ((r < 0 ? -r : r) != er[t]) bad_r++;
      end
      n_total++; if (bad_l != 0) $display("FAIL pan_left[%h]: %0d samples with |snd_l| != %0d", pv[t], bad_l, el[t]); else n_pass++;
      n_total++; if (bad_r != 0) $display("FAIL pan_right[%h]: %0d samples with |snd_r| != %0d", pv[t], bad_r, er[t]); else n_pass++;
    end
    pan_write(8'hFF);
  endtask

  task automatic test_fifo();
    logic [7:0] bytes [5] = '{8'h8A, 8'h00, 8'h9F, 8'hBF, 8'h90};
    logic       e_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       e_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic o, rd;
    int l, r, bad, k;
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_byte(bytes[i], o, rd);
      n_total++; if (rd !== e_rdy[i]) $display("FAIL fifo_ready[%0d]: got %b want %b", i, rd, e_rdy[i]); else n_pass++;
      n_total++; if (o !== e_ovf[i]) $display("FAIL fifo_ovf[%0d]: got %b want %b", i, o, e_ovf[i]); else n_pass++;
    end
    @(posedge clk);
    #1;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL fifo_ovf_pulse: got %b want 0 one clk later", bus.ovf); else n_pass++;
    clk_en = 1'b1;
    k = 0;
    while (bus.ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    n_total++; if (bus.ready !== 1'b1) $display("FAIL fifo_drain_ready: got %b want 1", bus.ready); else n_pass++;
    repeat (5) get_sample(l, r);
    bad = 0;
    repeat (10) begin
      get_sample(l, r);
      if (l != 0 || r != 0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL fifo_dropped_byte: %0d nonzero samples want 0", bad); else n_pass++;
  endtask

  task automatic test_noise();
    bit   obs[$];
    bit   mdl[$];
    logic [15:0] m;
    logic fbit;
    int l, r, k, amp_bad, mis, h, lo;
    wr_byte(8'hE4, d_ovf, d_rdy);
    wr_byte(8'hF0, d_ovf, d_rdy);
    k = 0; l = 0;
    do begin get_sample(l, r); k++; end while (l == 0 && k < 20);
    n_total++; if (l == 0) $display("FAIL noise_start: got snd_l=0 want +-255"); else n_pass++;
    obs.push_back(l > 0);
    amp_bad = 0;
    repeat (1600) begin
      get_sample(l, r);
      if ((l < 0 ? -l : l) != 255 || r != l) amp_bad++;
      if ((l > 0) != obs[$]) obs.push_back(l > 0);
    end
    m = 16'h8000;
    mdl.push_back(m[0]);
    repeat (100) begin
      fbit = m[0] ^ m[3];
      m = {fbit, m[15:1]};
      if (m[0] != mdl[$]) mdl.push_back(m[0]);
    end
    mis = 0;
    for (int i = 0; i < obs.size(); i++)
      if (i >= mdl.size() || obs[i] != mdl[i]) mis++;
    n_total++; if (amp_bad != 0) $display("FAIL noise_amp: %0d samples not +-255 or L!=R", amp_bad); else n_pass++;
    n_total++; if (obs.size() < 6) $display("FAIL noise_runs: got %0d runs want >=6", obs.size()); else n_pass++;
    n_total++; if (mis != 0) $display("FAIL noise_white_seq: %0d run mismatches vs LFSR model", mis); else n_pass++;

    wr_byte(8'hE0, d_ovf, d_rdy);
    repeat (4) get_sample(l, r);
    k = 0;
    while (l <= 0 && k < 700) begin get_sample(l, r); k++; end
    n_total++; if (l <= 0) $display("FAIL noise_periodic_high: got no +255 within 700 samples"); else n_pass++;
    h = 0;
    while (l > 0 && h < 200) begin h++; get_sample(l, r); end
    lo = 0;
    while (l < 0 && lo < 1000) begin lo++; get_sample(l, r); end
    n_total++; if (h == 0 || lo != 15 * h)
      $display("FAIL noise_periodic_ratio: high=%0d low=%0d want low=15*high", h, lo);
    else n_pass++;
    wr_byte(8'hFF, d_ovf, d_rdy);
  endtask

  task automatic test_midop();
    int l, r, bad;
    pan_write(8'h00);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    wr_byte(8'h90, d_ovf, d_rdy);
    wr_byte(8'h83, d_ovf, d_rdy);
    wr_byte(8'hB0, d_ovf, d_rdy);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (bus.ready !== 1'b1) $display("FAIL midop_ready: got %b want 1", bus.ready); else n_pass++;
    clk_en = 1'b1;
    bad = 0;
    repeat (40) begin
      get_sample(l, r);
      if (l != 0 || r != 0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL midop_discard: %0d nonzero samples want 0", bad); else n_pass++;
    wr_byte(8'h90, d_ovf, d_rdy);
    repeat (3) get_sample(l, r);
    get_sample(l, r);
    n_total++; if (l != 255 || r != 255) $display("FAIL midop_defaults: got l=%0d r=%0d want 255/255", l, r); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; clk_en = 1'b1;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.pan_we = 1'b0; bus.din = 8'h00;
    test_reset();
    test_tone();
    test_pan();
    test_fifo();
    test_noise();
    test_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
